ps2_keypad_rx: RTL

- Receives the PS/2 keyboard serial stream that hps_io drives on ps2_kbd_clk_out/ps2_kbd_data_out, i.e. the device-to-host end of that link.
- Deframes bytes, resolves E0 (extended) and F0 (break) prefixes, and emits scan-code events.
- Keeps a 25-bit held-key register that drives the System1 keypad switch inputs (sw0..swf, swrst, swm, swl, swg, swr, swp, swU, sws, swD), alongside the on-screen mouse keypad.
- Runs in the clk_25 domain.

---
 rtl/sys1_kbd_pkg.sv | 51 +++++
 rtl/ps2_line_filter.sv | 50 +++++
 rtl/ps2_keypad_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sys1_kbd_pkg.sv
// Shared types and constants for the System1 PS/2 keypad receiver:
// frame states, prefix bytes, keypad scan codes and their sw bit positions.
package sys1_kbd_pkg;

    typedef enum logic [1:0] {FS_IDLE, FS_DATA, FS_PARITY, FS_STOP} frame_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // {extended, scan byte}
    localparam logic [8:0] KC_0 = 9'h045, KC_1 = 9'h016, KC_2 = 9'h01E, KC_3 = 9'h026;
    localparam logic [8:0] KC_4 = 9'h025, KC_5 = 9'h02E, KC_6 = 9'h036, KC_7 = 9'h03D;
    localparam logic [8:0] KC_8 = 9'h03E, KC_9 = 9'h046, KC_A = 9'h01C, KC_B = 9'h032;
    localparam logic [8:0] KC_C = 9'h021, KC_D = 9'h023, KC_E = 9'h024, KC_F = 9'h02B;
    localparam logic [8:0] KC_RST = 9'h005, KC_M = 9'h03A, KC_L = 9'h04B, KC_G = 9'h034;
    localparam logic [8:0] KC_R = 9'h02D, KC_P = 9'h04D, KC_UP = 9'h175, KC_S = 9'h01B;
    localparam logic [8:0] KC_DN = 9'h172;

    localparam logic [4:0] SW_0 = 5'd0, SW_1 = 5'd1, SW_2 = 5'd2, SW_3 = 5'd3;
    localparam logic [4:0] SW_4 = 5'd4, SW_5 = 5'd5, SW_6 = 5'd6, SW_7 = 5'd7;
    localparam logic [4:0] SW_8 = 5'd8, SW_9 = 5'd9, SW_A = 5'd10, SW_B = 5'd11;
    localparam logic [4:0] SW_C = 5'd12, SW_D = 5'd13, SW_E = 5'd14, SW_F = 5'd15;
    localparam logic [4:0] SW_RST = 5'd16, SW_M = 5'd17, SW_L = 5'd18, SW_G = 5'd19;
    localparam logic [4:0] SW_R = 5'd20, SW_P = 5'd21, SW_UP = 5'd22, SW_S = 5'd23;
    localparam logic [4:0] SW_DN = 5'd24;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_map_t;

    function automatic key_map_t map_key(input logic [8:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = '0;
        case (code)
            KC_0:   m.idx = SW_0;    KC_1:  m.idx = SW_1;   KC_2:  m.idx = SW_2;
            KC_3:   m.idx = SW_3;    KC_4:  m.idx = SW_4;   KC_5:  m.idx = SW_5;
            KC_6:   m.idx = SW_6;    KC_7:  m.idx = SW_7;   KC_8:  m.idx = SW_8;
            KC_9:   m.idx = SW_9;    KC_A:  m.idx = SW_A;   KC_B:  m.idx = SW_B;
            KC_C:   m.idx = SW_C;    KC_D:  m.idx = SW_D;   KC_E:  m.idx = SW_E;
            KC_F:   m.idx = SW_F;    KC_RST: m.idx = SW_RST; KC_M: m.idx = SW_M;
            KC_L:   m.idx = SW_L;    KC_G:  m.idx = SW_G;   KC_R:  m.idx = SW_R;
            KC_P:   m.idx = SW_P;    KC_UP: m.idx = SW_UP;  KC_S:  m.idx = SW_S;
            KC_DN:  m.idx = SW_DN;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for one PS/2 line; optionally
// emits a one-cycle pulse on the filtered 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8,
    parameter bit          FALL_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sync2_q;
            else                                  cnt_d  = cnt_q + 1'b1;
        end
        fall_d = FALL_EN && filt_q && !filt_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level = filt_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_keypad_rx.sv
// PS/2 device-to-host receiver: deframes bytes, resolves E0/F0 prefixes into
// make/break events and tracks held System1 keypad keys in sw.
module ps2_keypad_rx
    import sys1_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [8:0]  key_code,
    output logic        key_pressed,
    output logic        key_strobe,
    output logic        frame_err,
    output logic        busy,
    output logic [24:0] sw
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic clk_fall, data_lvl, unused_data_fall, unused_clk_lvl;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .FALL_EN(1'b1)) u_clk_filt (
        .clk(clk), .reset(reset), .line_in(ps2_clk), .level(unused_clk_lvl), .fall(clk_fall)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .FALL_EN(1'b0)) u_data_filt (
        .clk(clk), .reset(reset), .line_in(ps2_data), .level(data_lvl), .fall(unused_data_fall)
    );

    frame_state_t    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            busy_q, busy_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [8:0]      key_code_q, key_code_d;
    logic            key_pressed_q, key_pressed_d;
    logic            key_strobe_q, key_strobe_d;
    logic [24:0]     sw_q, sw_d;
    key_map_t        km;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        wd_d          = '0;
        busy_d        = busy_q;
        byte_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        key_strobe_d  = 1'b0;
        sw_d          = sw_q;
        km            = map_key({ext_q, shift_q});

        if (clk_fall) begin
            case (state_q)
                FS_IDLE: if (!data_lvl) begin
                    state_d   = FS_DATA;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
                FS_DATA: begin
                    shift_d   = {data_lvl, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = FS_PARITY;
                end
                FS_PARITY: begin
                    parity_d = data_lvl;
                    state_d  = FS_STOP;
                end
                FS_STOP: begin
                    state_d = FS_IDLE;
                    busy_d  = 1'b0;
                    if (data_lvl && (^shift_q ^ parity_q)) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
                default: state_d = FS_IDLE;
            endcase
        end else if (state_q != FS_IDLE) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d     = FS_IDLE;
                busy_d      = 1'b0;
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        // The completed byte stays in shift_q: no new start bit can be
        // filtered through within one cycle of the stop edge.
        if (byte_valid_q) begin
            if (shift_q == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                key_code_d    = {ext_q, shift_q};
                key_pressed_d = ~brk_q;
                key_strobe_d  = 1'b1;
                ext_d         = 1'b0;
                brk_d         = 1'b0;
                if (km.hit) sw_d[km.idx] = ~brk_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wd_q          <= '0;
            busy_q        <= 1'b0;
            byte_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_code_q    <= '0;
            key_pressed_q <= 1'b0;
            key_strobe_q  <= 1'b0;
            sw_q          <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            wd_q          <= wd_d;
            busy_q        <= busy_d;
            byte_valid_q  <= byte_valid_d;
            frame_err_q   <= frame_err_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
            key_strobe_q  <= key_strobe_d;
            sw_q          <= sw_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;
    assign key_strobe  = key_strobe_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;
    assign sw          = sw_q;

endmodule
